// File: rtl/dmem_pkg.sv
// Shared types, widths and the alignment rule for the DMEM arbiter.
package dmem_pkg;

    localparam int N_REQ  = 2;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        BS_BYTE = 2'b00,
        BS_HALF = 2'b01,
        BS_WORD = 2'b10
    } byte_sel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic              wen;
        logic [1:0]        byte_sel;
        logic              sign;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dmem_cmd_t;

    // An access is rejected when its size code is reserved or when the
    // address is not a multiple of the access size.
    function automatic logic is_misaligned(input logic [1:0]        byte_sel,
                                           input logic [ADDR_W-1:0] addr);
        logic bad;
        case (byte_sel)
            BS_BYTE: bad = 1'b0;
            BS_HALF: bad = addr[0];
            BS_WORD: bad = (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: the port named by rr_ptr wins a tie.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       rr_ptr,
    output logic [1:0] grant,
    output logic       gnt_idx
);

    // Pick the preferred port if it asks, otherwise the other one.
    always_comb begin
        grant   = 2'b00;
        gnt_idx = rr_ptr;
        if (valid[rr_ptr]) begin
            gnt_idx = rr_ptr;
        end else if (valid[~rr_ptr]) begin
            gnt_idx = ~rr_ptr;
        end
        if (valid != 2'b00) begin
            grant[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port DMEM between the CPU LSU (port 0) and the debug
// loader (port 1). One access at a time: IDLE -> ACCESS -> RESP, or
// IDLE -> RESP directly for a rejected request.
//
// Request handshake: a transfer happens on the rising edge where
// REQ_VALID[i] and REQ_READY[i] are both 1. REQ_READY is only ever raised
// for the single granted port while the arbiter is IDLE, and the
// requester must hold its REQ_* fields stable until that edge. Responses
// have no back-pressure: RSP_VALID is a one-cycle pulse that must be taken.
module dmem_arbiter
    import dmem_pkg::*;
(
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [N_REQ-1:0]               REQ_VALID,
    output logic [N_REQ-1:0]               REQ_READY,
    input  logic [N_REQ-1:0]               REQ_WEN,
    input  logic [N_REQ-1:0][1:0]          REQ_BYTE_SEL,
    input  logic [N_REQ-1:0]               REQ_SIGN,
    input  logic [N_REQ-1:0][ADDR_W-1:0]   REQ_ADDR,
    input  logic [N_REQ-1:0][DATA_W-1:0]   REQ_WDATA,
    output logic [N_REQ-1:0]               RSP_VALID,
    output logic [DATA_W-1:0]              RSP_RDATA,
    output logic                           RSP_ERR,
    output logic                           DMEM_RDEN,
    output logic                           DMEM_WEN,
    output logic [1:0]                     DMEM_BYTE_SEL,
    output logic                           DMEM_SIGN,
    output logic [ADDR_W-1:0]              DMEM_ADDR,
    output logic [DATA_W-1:0]              DMEM_DATA_IN,
    input  logic [DATA_W-1:0]              DMEM_DATA_OUT,
    output arb_state_t                     dbg_state
);

    arb_state_t state;
    logic       rr_ptr;
    logic       owner;
    logic       err;
    dmem_cmd_t  cmd;

    logic [1:0] grant;
    logic       gnt_idx;
    logic       handshake;
    logic       req_bad;
    dmem_cmd_t  req_cmd;

    rr_arbiter2 u_rr (
        .valid   (REQ_VALID),
        .rr_ptr  (rr_ptr),
        .grant   (grant),
        .gnt_idx (gnt_idx)
    );

    assign REQ_READY = (state == IDLE && !RST) ? grant : '0;
    assign handshake = |(REQ_READY & REQ_VALID);

    // Gather the granted port's request and classify it.
    always_comb begin
        req_cmd.wen      = REQ_WEN[gnt_idx];
        req_cmd.byte_sel = REQ_BYTE_SEL[gnt_idx];
        req_cmd.sign     = REQ_SIGN[gnt_idx];
        req_cmd.addr     = REQ_ADDR[gnt_idx];
        req_cmd.wdata    = REQ_WDATA[gnt_idx];
        req_bad          = is_misaligned(req_cmd.byte_sel, req_cmd.addr);
    end

    // The command register only loads on accepted legal requests, so the
    // DMEM address/data pins hold their last value outside ACCESS.
    assign DMEM_BYTE_SEL = cmd.byte_sel;
    assign DMEM_SIGN     = cmd.sign;
    assign DMEM_ADDR     = cmd.addr;
    assign DMEM_DATA_IN  = cmd.wdata;

    // DMEM presents load data in the RESP cycle; pass it only for a good load.
    assign RSP_RDATA = (state == RESP && !err && !cmd.wen) ? DMEM_DATA_OUT : '0;

    assign dbg_state = state;

    // Arbitration FSM with registered strobes and response pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            owner     <= 1'b0;
            err       <= 1'b0;
            cmd       <= '0;
            DMEM_RDEN <= 1'b0;
            DMEM_WEN  <= 1'b0;
            RSP_VALID <= '0;
            RSP_ERR   <= 1'b0;
        end else begin
            DMEM_RDEN <= 1'b0;
            DMEM_WEN  <= 1'b0;
            RSP_VALID <= '0;
            RSP_ERR   <= 1'b0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        owner  <= gnt_idx;
                        rr_ptr <= ~gnt_idx;
                        err    <= req_bad;
                        if (req_bad) begin
                            state     <= RESP;
                            RSP_VALID <= 2'b01 << gnt_idx;
                            RSP_ERR   <= 1'b1;
                        end else begin
                            state     <= ACCESS;
                            cmd       <= req_cmd;
                            DMEM_RDEN <= ~req_cmd.wen;
                            DMEM_WEN  <= req_cmd.wen;
                        end
                    end
                end
                ACCESS: begin
                    state     <= RESP;
                    RSP_VALID <= 2'b01 << owner;
                    RSP_ERR   <= err;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter with a byte-level
// reference memory and a transaction-level timing model.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]              req_valid = '0;
    logic [1:0]              req_ready;
    logic [1:0]              req_wen = '0;
    logic [1:0][1:0]         req_byte_sel = '0;
    logic [1:0]              req_sign = '0;
    logic [1:0][ADDR_W-1:0]  req_addr = '0;
    logic [1:0][DATA_W-1:0]  req_wdata = '0;
    logic [1:0]              rsp_valid;
    logic [DATA_W-1:0]       rsp_rdata;
    logic                    rsp_err;
    logic                    dmem_rden, dmem_wen, dmem_sign;
    logic [1:0]              dmem_byte_sel;
    logic [ADDR_W-1:0]       dmem_addr;
    logic [DATA_W-1:0]       dmem_data_in;
    logic [DATA_W-1:0]       dmem_data_out = '0;
    arb_state_t              dbg_state;

    dmem_arbiter u_dut (
        .CLK(clk), .RST(rst),
        .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WEN(req_wen),
        .REQ_BYTE_SEL(req_byte_sel), .REQ_SIGN(req_sign), .REQ_ADDR(req_addr),
        .REQ_WDATA(req_wdata),
        .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
        .DMEM_RDEN(dmem_rden), .DMEM_WEN(dmem_wen), .DMEM_BYTE_SEL(dmem_byte_sel),
        .DMEM_SIGN(dmem_sign), .DMEM_ADDR(dmem_addr), .DMEM_DATA_IN(dmem_data_in),
        .DMEM_DATA_OUT(dmem_data_out),
        .dbg_state(dbg_state)
    );

    // ---------------- DMEM device model (word array, lane shifts) ----------------
    logic [31:0] dmem_words [0:4095];

    function automatic logic [31:0] dmem_rd(input logic [31:0] w, input logic [1:0] bs,
                                            input logic sign, input logic [1:0] lane);
        logic [31:0] s;
        s = w >> {lane, 3'b000};
        case (bs)
            2'b00:   return {{24{sign & s[7]}}, s[7:0]};
            2'b01:   return {{16{sign & s[15]}}, s[15:0]};
            default: return w;
        endcase
    endfunction

    always @(posedge clk) begin
        if (dmem_wen) begin
            case (dmem_byte_sel)
                2'b00:   dmem_words[dmem_addr[13:2]][{dmem_addr[1:0], 3'b000} +: 8] <= dmem_data_in[7:0];
                2'b01:   dmem_words[dmem_addr[13:2]][{dmem_addr[1], 4'b0000} +: 16] <= dmem_data_in[15:0];
                default: dmem_words[dmem_addr[13:2]] <= dmem_data_in;
            endcase
        end
        if (dmem_rden) begin
            dmem_data_out <= dmem_rd(dmem_words[dmem_addr[13:2]], dmem_byte_sel, dmem_sign, dmem_addr[1:0]);
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [0:63];

    typedef struct {
        int          cyc;
        int          owner;
        logic        err;
        logic [31:0] rdata;
    } exp_rsp_t;
    exp_rsp_t rsp_q[$];
    int gnt_log[$];

    int          cyc = 0;
    int          free_cyc = 0;
    int          last_gnt = 1;
    int          stb_cyc = -1;
    logic        stb_wen;
    logic [1:0]  stb_bs;
    logic        stb_sign;
    logic [31:0] stb_addr;
    logic [31:0] stb_wdata;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int size_of(input logic [1:0] bs);
        return (bs == 2'b00) ? 1 : (bs == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic legal_req(input logic [1:0] bs, input int addr);
        if (bs == 2'b11) return 1'b0;
        return (addr % size_of(bs)) == 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] bs, input logic sign, input int addr);
        logic [31:0] v;
        int n;
        n = size_of(bs);
        v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[addr + i]) << (8 * i));
        if (sign && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] bs, input int addr, input logic [31:0] data);
        for (int i = 0; i < size_of(bs); i++) ref_mem[addr + i] = data[8 * i +: 8];
    endtask

    // ---------------- one clock of checking + model update ----------------
    task automatic step();
        logic [1:0]  exp_ready;
        int          g;
        logic        was_rst;
        logic [31:0] rd;
        @(negedge clk);
        cyc++;
        was_rst = rst;
        exp_ready = 2'b00;
        g = -1;
        if (!rst && cyc >= free_cyc && req_valid != 2'b00) begin
            if (req_valid == 2'b11) g = (last_gnt == 0) ? 1 : 0;
            else g = req_valid[1] ? 1 : 0;
            exp_ready[g] = 1'b1;
        end
        chk("req_ready", req_ready, exp_ready);

        if (stb_cyc == cyc) begin
            chk("dmem_rden", dmem_rden, !stb_wen);
            chk("dmem_wen", dmem_wen, stb_wen);
            chk("dmem_addr", dmem_addr, stb_addr);
            chk("dmem_byte_sel", dmem_byte_sel, stb_bs);
            if (stb_wen) chk("dmem_data_in", dmem_data_in, stb_wdata);
            else chk("dmem_sign", dmem_sign, stb_sign);
        end else begin
            chk("dmem_strobe_idle", {dmem_rden, dmem_wen}, 2'b00);
        end

        if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
            chk("rsp_valid", rsp_valid, 2'b01 << rsp_q[0].owner);
            chk("rsp_err", rsp_err, rsp_q[0].err);
            chk("rsp_rdata", rsp_rdata, rsp_q[0].rdata);
            void'(rsp_q.pop_front());
        end else begin
            chk("rsp_valid_idle", rsp_valid, 2'b00);
        end

        if (was_rst) begin
            rsp_q.delete();
            stb_cyc  = -1;
            free_cyc = cyc + 1;
            last_gnt = 1;
        end else if (g >= 0) begin
            gnt_log.push_back(g);
            last_gnt = g;
            if (!legal_req(req_byte_sel[g], int'(req_addr[g]))) begin
                rsp_q.push_back('{cyc + 1, g, 1'b1, 32'h0});
                free_cyc = cyc + 2;
            end else begin
                stb_cyc   = cyc + 1;
                stb_wen   = req_wen[g];
                stb_bs    = req_byte_sel[g];
                stb_sign  = req_sign[g];
                stb_addr  = 32'(req_addr[g]);
                stb_wdata = req_wdata[g];
                if (req_wen[g]) begin
                    ref_store(req_byte_sel[g], int'(req_addr[g]), req_wdata[g]);
                    rd = 32'h0;
                end else begin
                    rd = ref_load(req_byte_sel[g], req_sign[g], int'(req_addr[g]));
                end
                rsp_q.push_back('{cyc + 2, g, 1'b0, rd});
                free_cyc = cyc + 3;
            end
        end
        @(posedge clk);
        #1;
        if (g >= 0) req_valid[g] = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic put(input int p, input logic wen, input logic [1:0] bs, input logic sign,
                       input int addr, input logic [31:0] wdata);
        req_wen[p]      = wen;
        req_byte_sel[p] = bs;
        req_sign[p]     = sign;
        req_addr[p]     = ADDR_W'(addr);
        req_wdata[p]    = wdata;
        req_valid[p]    = 1'b1;
    endtask

    task automatic wait_grant(input int p);
        for (int i = 0; i < 20 && req_valid[p]; i++) step();
        chk("grant_timeout", req_valid[p], 1'b0);
        req_valid[p] = 1'b0;
    endtask

    task automatic drain();
        repeat (4) step();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_dmem_addr", dmem_addr, '0);
        chk("rst_dmem_data_in", dmem_data_in, '0);
        chk("rst_dmem_byte_sel", dmem_byte_sel, 2'b00);
        chk("rst_dmem_sign", dmem_sign, 1'b0);
        chk("rst_strobes", {dmem_rden, dmem_wen}, 2'b00);
        chk("rst_rsp", {rsp_valid, rsp_err}, 3'b000);
        chk("rst_rdata", rsp_rdata, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        chk_reset_outputs();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin
        int n0, n1;
        for (int i = 0; i < 4096; i++) dmem_words[i] = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        @(posedge clk);
        #1;
        do_reset();

        // word store then word load on port 0
        put(0, 1'b1, 2'b10, 1'b0, 0, 32'hDEADBEE0); wait_grant(0); drain();
        put(0, 1'b0, 2'b10, 1'b0, 0, 32'h0);        wait_grant(0); drain();

        // both ports continuously valid from reset: strict alternation
        do_reset();
        gnt_log.delete();
        put(0, 1'b0, 2'b10, 1'b0, 0, 32'h0);
        put(1, 1'b0, 2'b10, 1'b0, 4, 32'h0);
        n0 = 1; n1 = 1;
        for (int i = 0; i < 60 && (n0 < 4 || n1 < 4 || req_valid != 2'b00); i++) begin
            step();
            if (!req_valid[0] && n0 < 4) begin put(0, 1'b0, 2'b10, 1'b0, 4 * n0, 32'h0); n0++; end
            if (!req_valid[1] && n1 < 4) begin put(1, 1'b0, 2'b10, 1'b0, 4 * n1 + 16, 32'h0); n1++; end
        end
        drain();
        chk("grant_count", gnt_log.size(), 8);
        for (int i = 0; i < gnt_log.size(); i++) chk("grant_order", gnt_log[i], i % 2);

        // rejected requests on port 1
        put(1, 1'b1, 2'b10, 1'b0, 1, 32'h1111_1111); wait_grant(1); drain();
        put(1, 1'b1, 2'b01, 1'b0, 3, 32'h2222_2222); wait_grant(1); drain();
        put(1, 1'b1, 2'b11, 1'b0, 4, 32'h3333_3333); wait_grant(1); drain();
        put(1, 1'b0, 2'b10, 1'b0, 0, 32'h0);         wait_grant(1); drain();
        put(1, 1'b0, 2'b10, 1'b0, 4, 32'h0);         wait_grant(1); drain();

        // half loads with and without sign extension
        put(0, 1'b1, 2'b10, 1'b0, 8, 32'hDEADBEE8); wait_grant(0); drain();
        put(0, 1'b0, 2'b01, 1'b1, 8, 32'h0);        wait_grant(0); drain();
        put(0, 1'b0, 2'b01, 1'b0, 8, 32'h0);        wait_grant(0); drain();
        chk("half_sext_ref", ref_load(2'b01, 1'b1, 8), 32'hFFFF_BEE8);
        chk("half_zext_ref", ref_load(2'b01, 1'b0, 8), 32'h0000_BEE8);

        // signed byte load
        put(0, 1'b1, 2'b10, 1'b0, 12, 32'hDEADBEEC); wait_grant(0); drain();
        put(0, 1'b0, 2'b00, 1'b1, 12, 32'h0);        wait_grant(0); drain();

        // reset during the ACCESS cycle of a port 1 load
        put(1, 1'b0, 2'b10, 1'b0, 8, 32'h0);
        wait_grant(1);
        rst = 1'b1;
        step();
        chk_reset_outputs();
        rst = 1'b0;
        gnt_log.delete();
        put(0, 1'b0, 2'b10, 1'b0, 12, 32'h0);
        put(1, 1'b0, 2'b10, 1'b0, 8, 32'h0);
        wait_grant(0);
        wait_grant(1);
        drain();
        chk("post_reset_first_grant", gnt_log.size() > 0 ? gnt_log[0] : -1, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req_valid[p] && $urandom_range(0, 99) < 50) begin
                    put(p, 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                        1'($urandom_range(0, 1)),
                        $urandom_range(0, 15) * 4 + (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0),
                        $urandom);
                end
            end
            step();
        end
        for (int i = 0; i < 20 && req_valid != 2'b00; i++) step();
        chk("random_drain", req_valid, 2'b00);
        req_valid = 2'b00;
        drain();
        chk("rsp_queue_empty", rsp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port DMEM between two requesters.
  - Port 0: CPU load/store unit.
  - Port 1: debug/program loader.
- Round-robin grant with valid/ready request handshake.
- Rejects misaligned or illegal accesses before they reach DMEM.
- Sequences the DMEM strobes and returns read data with a response pulse.
- Sits between the pipeline MEM stage / debug bridge and DMEM.

Parameters:
- N_REQ, 2, number of requesters (fixed at 2 for this revision)
- ADDR_W, 14, DMEM byte-address width
- DATA_W, 32, data width

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- REQ_VALID  in  [N_REQ-1:0]  request present
- REQ_READY  out  [N_REQ-1:0]  request accepted this cycle
- REQ_WEN  in  [N_REQ-1:0]  1=store, 0=load
- REQ_BYTE_SEL  in  [N_REQ-1:0][1:0]  00 byte, 01 half, 10 word, 11 illegal
- REQ_SIGN  in  [N_REQ-1:0]  sign-extend on load
- REQ_ADDR  in  [N_REQ-1:0][ADDR_W-1:0]  byte address
- REQ_WDATA  in  [N_REQ-1:0][DATA_W-1:0]  store data
- RSP_VALID  out  [N_REQ-1:0]  one-cycle response pulse to the owning requester
- RSP_RDATA  out  DATA_W  load data, shared bus, qualified by RSP_VALID
- RSP_ERR  out  1  response is an alignment/illegal error
- DMEM_RDEN  out  1  DMEM read enable
- DMEM_WEN  out  1  DMEM write enable
- DMEM_BYTE_SEL  out  2  to DMEM BYTE_SEL
- DMEM_SIGN  out  1  to DMEM SIGN
- DMEM_ADDR  out  ADDR_W  to DMEM ADDR
- DMEM_DATA_IN  out  DATA_W  to DMEM DATA_IN
- DMEM_DATA_OUT  in  DATA_W  from DMEM DATA_OUT; valid the cycle after the RDEN edge

Behaviour:
- Reset: one clock (CLK); reset is synchronous, active-high (RST).
  - State=IDLE, rr_ptr=0 (port 0 preferred).
  - All DMEM_* outputs 0; REQ_READY=0, RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Grant goes to the valid port nearest rr_ptr.
    - Both valid: the port equal to rr_ptr wins.
    - Only one valid: that port wins.
  - REQ_READY[g]=1 combinationally for the granted port only.
  - On the handshake edge, latch the request into cmd regs, record owner=g, set rr_ptr=~g.
  - Legal request -> ACCESS. Misaligned/illegal request -> RESP with err=1.
- Misaligned/illegal definition:
  - BYTE_SEL=11.
  - Half with ADDR[0]=1.
  - Word with ADDR[1:0]!=0.
- ACCESS (exactly 1 cycle):
  - DMEM_RDEN=~wen, DMEM_WEN=wen.
  - DMEM_ADDR/BYTE_SEL/SIGN/DATA_IN driven from cmd regs (registered, glitch-free).
  - Next state RESP.
- RESP (exactly 1 cycle):
  - RSP_VALID[owner]=1.
  - RSP_ERR=err.
  - RSP_RDATA=DMEM_DATA_OUT for a legal load; 0 for a store or an error.
  - DMEM strobes are 0 in RESP.
  - Next state IDLE.
- Latency: handshake at edge N -> strobes in cycle N+1 -> RSP_VALID in cycle N+2.
  - Throughput: 1 access per 3 cycles.
  - Error response: RSP_VALID in cycle N+1, DMEM untouched.
- No response back-pressure: the requester must accept RSP_VALID.
  - A requester may keep REQ_VALID high while waiting; it is not re-granted until IDLE.
- Outside ACCESS: DMEM_RDEN=DMEM_WEN=0 and DMEM_DATA_IN holds its last value.
- Fairness: with both ports continuously valid, grants strictly alternate.
  - Max wait for any port is one other transaction (3 cycles).
- RST mid-operation (any state): next edge returns to the reset state.
  - An in-flight strobe is dropped after that edge.
  - No RSP_VALID is emitted for the aborted transaction.
- REQ_* inputs of a non-granted port are ignored; they are sampled only at its handshake.

Decomposition:
- Package dmem_pkg:
  - ADDR_W, DATA_W.
  - byte_sel_t enum: BS_BYTE=2'b00, BS_HALF=2'b01, BS_WORD=2'b10.
  - arb_state_t enum: IDLE, ACCESS, RESP.
  - Packed dmem_cmd_t struct: wen, byte_sel, sign, addr, wdata.
  - Function is_misaligned(byte_sel, addr).
- Sub-module rr_arbiter2:
  - Purely combinational grant from valid[1:0] and rr_ptr.
  - Outputs grant[1:0] and gnt_idx.
  - rr_ptr register stays in dmem_arbiter.

Test Plan:
1. P0 word store ADDR=0x0000 DATA=0xDEADBEE0, then P0 word load ADDR=0x0000 -> DMEM_WEN pulses 1 cycle after handshake; load RSP_VALID[0] at N+2 with RSP_RDATA=0xDEADBEE0, RSP_ERR=0.
2. P0 and P1 both valid from reset, 4 back-to-back word loads each -> grant order 0,1,0,1,...; REQ_READY asserted every 3 cycles; responses route to the correct RSP_VALID bit.
3. P1 word store ADDR=0x0001, half store ADDR=0x0003, BYTE_SEL=11 -> each returns RSP_VALID[1] with RSP_ERR=1 one cycle after handshake; DMEM_WEN/RDEN never asserted; memory unchanged.
4. Store 0xDEADBEE8 at 0x0008, then half load ADDR=0x0008 SIGN=1 -> RSP_RDATA=0xFFFFBEE8; same with SIGN=0 -> 0x0000BEE8.
5. Byte load ADDR=0x000C SIGN=1 after word 0xDEADBEEC stored there -> RSP_RDATA=0xFFFFFFEC.
6. RST asserted in the ACCESS cycle of a P1 load -> no RSP_VALID; after release, simultaneous P0/P1 requests grant P0 first.
